mips_multicycle_control: RTL and testbench

Main control unit for the multicycle MIPS core, successor to the single-cycle decoder. It sequences every instruction through a Moore FSM (fetch, decode, execute, memory, writeback) and sequences memory accesses through a req/ready handshake, so any memory latency is tolerated. It adds optional J and BNE support, illegal-instruction flagging and a retired-instruction counter. It sits between the instruction register (opcode/funct) and the multicycle datapath muxes and enables.

---
 rtl/mips_multicycle_control.sv | 206 ++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS core: sequences each instruction through
// fetch/decode/execute/memory/writeback with a req/ready memory handshake.
module mips_multicycle_control #(
  parameter int OPCODE_W   = 6,
  parameter int FUNCT_W    = 6,
  parameter int ALU_CTRL_W = 3,
  parameter int CNT_W      = 32,
  parameter bit EN_JUMP    = 1'b1,
  parameter bit EN_BNE     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  iord,
  output logic                  ir_write,
  output logic                  pc_en,
  output logic [1:0]            pc_src,
  output logic                  reg_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  illegal,
  output logic [3:0]            state,
  output logic [CNT_W-1:0]      instr_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);

  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(6'b101010);

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b000);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b001);
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b010);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b110);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b111);

  state_t cur, nxt;
  logic   retire;
  // Instruction class is captured in DECODE so later states never look at opcode.
  logic   is_store, is_bne;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= FETCH;
      instr_count <= '0;
      is_store    <= 1'b0;
      is_bne      <= 1'b0;
    end else begin
      cur <= nxt;
      if (retire) instr_count <= instr_count + 1'b1;
      if (cur == DECODE) begin
        is_store <= (opcode == OP_SW);
        is_bne   <= (opcode == OP_BNE);
      end
    end
  end

  assign state = cur;

  always_comb begin
    nxt        = FETCH;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    illegal    = 1'b0;

    case (cur)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        nxt       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW)              nxt = MEMADR;
        else if (opcode == OP_R)                             nxt = EXEC;
        else if (opcode == OP_BEQ || (EN_BNE && opcode == OP_BNE)) nxt = BRANCH;
        else if (opcode == OP_ADDI)                          nxt = ADDIEX;
        else if (EN_JUMP && opcode == OP_J)                  nxt = JUMP;
        else begin
          illegal = 1'b1;
          nxt     = FETCH;
        end
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = is_store ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        nxt     = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
        nxt       = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        nxt       = ALUWB;
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: begin
            illegal = 1'b1;
            nxt     = FETCH;
          end
        endcase
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = is_bne ? !zero : zero;
        retire    = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
        retire = 1'b1;
      end
      default: nxt = FETCH;
    endcase

    // A reset cycle must never leak a strobe into the datapath or memory.
    if (rst) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: a default instance plus one built with
// EN_JUMP=0 and CNT_W=4, both driven by the same stimulus.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;

  logic        mem_req, mem_write, iord, ir_write, pc_en, reg_write, reg_dst;
  logic        mem_to_reg, alu_src_a, illegal;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  alu_ctrl;
  logic [3:0]  state;
  logic [31:0] instr_count;

  logic        d1_mem_req, d1_mem_write, d1_iord, d1_ir_write, d1_pc_en, d1_reg_write;
  logic        d1_reg_dst, d1_mem_to_reg, d1_alu_src_a, d1_illegal;
  logic [1:0]  d1_pc_src, d1_alu_src_b;
  logic [2:0]  d1_alu_ctrl;
  logic [3:0]  d1_state;
  logic [3:0]  d1_instr_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .illegal(illegal), .state(state),
    .instr_count(instr_count)
  );

  mips_multicycle_control #(.CNT_W(4), .EN_JUMP(1'b0)) dut_small (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(d1_mem_req), .mem_write(d1_mem_write),
    .iord(d1_iord), .ir_write(d1_ir_write), .pc_en(d1_pc_en), .pc_src(d1_pc_src),
    .reg_write(d1_reg_write), .reg_dst(d1_reg_dst), .mem_to_reg(d1_mem_to_reg),
    .alu_src_a(d1_alu_src_a), .alu_src_b(d1_alu_src_b), .alu_ctrl(d1_alu_ctrl),
    .illegal(d1_illegal), .state(d1_state), .instr_count(d1_instr_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; opcode = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    go(); go();
    check("rst_state", 32'(state), 32'd0);
    check("rst_mem_req_forced", 32'(mem_req), 32'd0);
    check("rst_ir_write_forced", 32'(ir_write), 32'd0);
    check("rst_pc_en_forced", 32'(pc_en), 32'd0);
    check("rst_count", instr_count, 32'd0);
    rst = 1'b0;
    #1;
    check("fetch_mem_req", 32'(mem_req), 32'd1);
    check("fetch_ir_write", 32'(ir_write), 32'd1);
    check("fetch_alu_src_b", 32'(alu_src_b), 32'd1);

    // R-type ADD
    opcode = 6'b000000; funct = 6'b100000;
    go();
    check("add_decode_state", 32'(state), 32'd1);
    check("add_decode_srcb", 32'(alu_src_b), 32'd3);
    go();
    check("add_exec_state", 32'(state), 32'd6);
    check("add_exec_aluctrl", 32'(alu_ctrl), 32'd2);
    check("add_exec_srca", 32'(alu_src_a), 32'd1);
    go();
    check("add_wb_state", 32'(state), 32'd7);
    check("add_wb_regwrite", 32'(reg_write), 32'd1);
    check("add_wb_regdst", 32'(reg_dst), 32'd1);
    check("add_wb_count", instr_count, 32'd0);
    go();
    check("add_done_state", 32'(state), 32'd0);
    check("add_done_count", instr_count, 32'd1);

    // LW with three wait cycles in MEMRD
    opcode = 6'b100011;
    go();
    go();
    check("lw_memadr_state", 32'(state), 32'd2);
    check("lw_memadr_srcb", 32'(alu_src_b), 32'd2);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      go();
      check("lw_wait_state", 32'(state), 32'd3);
      check("lw_wait_req", 32'(mem_req), 32'd1);
      check("lw_wait_iord", 32'(iord), 32'd1);
    end
    mem_ready = 1'b1;
    #1;
    check("lw_ready_req", 32'(mem_req), 32'd1);
    go();
    check("lw_memwb_state", 32'(state), 32'd4);
    check("lw_memwb_memtoreg", 32'(mem_to_reg), 32'd1);
    check("lw_memwb_regwrite", 32'(reg_write), 32'd1);
    check("lw_memwb_regdst", 32'(reg_dst), 32'd0);
    go();
    check("lw_done_state", 32'(state), 32'd0);
    check("lw_done_count", instr_count, 32'd2);

    // BEQ taken, then BNE with zero=1 (not taken), then zero=0 (taken)
    opcode = 6'b000100; zero = 1'b1;
    go(); go();
    check("beq_state", 32'(state), 32'd8);
    check("beq_pc_en", 32'(pc_en), 32'd1);
    check("beq_pc_src", 32'(pc_src), 32'd1);
    check("beq_aluctrl", 32'(alu_ctrl), 32'd6);
    go();
    check("beq_count", instr_count, 32'd3);
    opcode = 6'b000101;
    go(); go();
    check("bne_state", 32'(state), 32'd8);
    check("bne_pc_en_zero1", 32'(pc_en), 32'd0);
    zero = 1'b0;
    #1;
    check("bne_pc_en_zero0", 32'(pc_en), 32'd1);
    go();
    check("bne_done_state", 32'(state), 32'd0);
    check("bne_count", instr_count, 32'd4);

    // Illegal opcode, then unknown funct
    opcode = 6'b111111;
    go();
    check("illop_pulse", 32'(illegal), 32'd1);
    go();
    check("illop_state", 32'(state), 32'd0);
    check("illop_cleared", 32'(illegal), 32'd0);
    check("illop_count", instr_count, 32'd4);
    opcode = 6'b000000; funct = 6'b000111;
    go();
    check("illfn_decode_ok", 32'(illegal), 32'd0);
    go();
    check("illfn_exec_state", 32'(state), 32'd6);
    check("illfn_pulse", 32'(illegal), 32'd1);
    check("illfn_no_wb", 32'(reg_write), 32'd0);
    go();
    check("illfn_state", 32'(state), 32'd0);
    check("illfn_regwrite", 32'(reg_write), 32'd0);
    check("illfn_count", instr_count, 32'd4);

    // J: decoded on the default instance, illegal when EN_JUMP=0
    opcode = 6'b000010;
    go();
    check("j_decode_legal", 32'(illegal), 32'd0);
    check("nj_decode_illegal", 32'(d1_illegal), 32'd1);
    go();
    check("j_state", 32'(state), 32'd11);
    check("j_pc_en", 32'(pc_en), 32'd1);
    check("j_pc_src", 32'(pc_src), 32'd2);
    check("nj_state", 32'(d1_state), 32'd0);
    check("nj_count", 32'(d1_instr_count), 32'd4);

    rst = 1'b1;
    go();
    rst = 1'b0;
    check("rst2_count", instr_count, 32'd0);

    // 16 ADDIs: 4-bit counter wraps, 32-bit counter reaches 16
    opcode = 6'b001000;
    for (int i = 0; i < 16; i++) begin
      go(); go();
      if (i == 0) begin
        check("addi_ex_state", 32'(state), 32'd9);
        check("addi_ex_srcb", 32'(alu_src_b), 32'd2);
      end
      go();
      if (i == 0) begin
        check("addi_wb_regwrite", 32'(reg_write), 32'd1);
        check("addi_wb_regdst", 32'(reg_dst), 32'd0);
      end
      go();
      if (i == 14) check("wrap_count_15", 32'(d1_instr_count), 32'd15);
    end
    check("wrap_count_0", 32'(d1_instr_count), 32'd0);
    check("addi_count_16", instr_count, 32'd16);

    // SW stalled in MEMWR, then reset abandons it
    opcode = 6'b101011;
    go(); go();
    check("sw_memadr_state", 32'(state), 32'd2);
    mem_ready = 1'b0;
    go();
    check("sw_memwr_state", 32'(state), 32'd5);
    check("sw_memwr_write", 32'(mem_write), 32'd1);
    go();
    check("sw_hold_req", 32'(mem_req), 32'd1);
    check("sw_hold_iord", 32'(iord), 32'd1);
    rst = 1'b1;
    #1;
    check("sw_rst_write_forced", 32'(mem_write), 32'd0);
    check("sw_rst_req_forced", 32'(mem_req), 32'd0);
    go();
    check("sw_rst_state", 32'(state), 32'd0);
    check("sw_rst_write", 32'(mem_write), 32'd0);
    check("sw_rst_count", instr_count, 32'd0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
